// File: rtl/mem_bist_pkg.sv
// Shared types and defaults for the memory BIST sequencer and its compare stage.
package mem_bist_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 512;
  localparam int RD_LAT_DEF = 1;
  localparam int ERR_W_DEF  = 16;

  typedef enum logic [2:0] {IDLE, W0, R0, WA, RA, DONE} state_t;

  localparam logic PH_R0 = 1'b0;
  localparam logic PH_RA = 1'b1;

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-data checker: delays expected value/address to line up with mem_rdata,
// counts miscompares (saturating) and captures the first failing location.
module mem_bist_cmp #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int ERR_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] exp,
  input  logic                  phase,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  fail_phase
);

  // Stage 1 is loaded on the edge where the memory samples the read.
  logic [RD_LATENCY:1]                 vld_pipe;
  logic [RD_LATENCY:1]                 ph_pipe;
  logic [RD_LATENCY:1][DATA_WIDTH-1:0] exp_pipe;
  logic [RD_LATENCY:1][ADDR_WIDTH-1:0] addr_pipe;
  logic                                miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      ph_pipe   <= '0;
      exp_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[1]  <= rd;
      ph_pipe[1]   <= phase;
      exp_pipe[1]  <= exp;
      addr_pipe[1] <= addr;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        ph_pipe[i]   <= ph_pipe[i-1];
        exp_pipe[i]  <= exp_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign miss = vld_pipe[RD_LATENCY] && (rdata != exp_pipe[RD_LATENCY]);

  // err_count never returns to zero within a run, so zero marks "no fail yet".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count  <= '0;
      fail_addr  <= '0;
      fail_data  <= '0;
      fail_phase <= 1'b0;
    end else if (clr) begin
      err_count  <= '0;
      fail_addr  <= '0;
      fail_data  <= '0;
      fail_phase <= 1'b0;
    end else if (miss) begin
      if (err_count == '0) begin
        fail_addr  <= addr_pipe[RD_LATENCY];
        fail_data  <= rdata;
        fail_phase <= ph_pipe[RD_LATENCY];
      end
      if (err_count != '1) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// March BIST sequencer: W0, R0, WA, RA over the whole memory, with registered
// memory strobes and a drain after each read phase for the read pipeline.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int MEM_DEPTH  = DEPTH_DEF,
  parameter int RD_LATENCY = RD_LAT_DEF,
  parameter int ERR_W      = ERR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  fail_phase,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam int                    DCW   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [DCW-1:0]        DLAST = DCW'(RD_LATENCY - 1);

  state_t                          st, st_nxt;
  logic                            drain, drain_nxt;
  logic [DCW-1:0]                  dcnt, dcnt_nxt;
  logic [ADDR_WIDTH-1:0]           addr_nxt;
  logic                            clr;
  logic                            rd_d, wr_d, busy_d, done_d, phase_d, phase_q;
  logic [DATA_WIDTH-1:0]           wdata_d, exp_d, exp_q, pat;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] ext;

  // State, address counter and all strobes/data are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      drain     <= 1'b0;
      dcnt      <= '0;
      mem_addr  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_wdata <= '0;
      exp_q     <= '0;
      phase_q   <= PH_R0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      st        <= st_nxt;
      drain     <= drain_nxt;
      dcnt      <= dcnt_nxt;
      mem_addr  <= addr_nxt;
      mem_read  <= rd_d;
      mem_write <= wr_d;
      mem_wdata <= wdata_d;
      exp_q     <= exp_d;
      phase_q   <= phase_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    st_nxt    = st;
    drain_nxt = drain;
    dcnt_nxt  = dcnt;
    addr_nxt  = mem_addr;
    clr       = 1'b0;
    case (st)
      IDLE, DONE: begin
        if (start) begin
          st_nxt   = W0;
          addr_nxt = '0;
          clr      = 1'b1;
        end
      end
      W0, WA: begin
        if (mem_addr == LAST) begin
          st_nxt   = (st == W0) ? R0 : RA;
          addr_nxt = '0;
        end else begin
          addr_nxt = mem_addr + 1'b1;
        end
      end
      R0, RA: begin
        if (!drain) begin
          if (mem_addr == LAST) begin
            drain_nxt = 1'b1;
            dcnt_nxt  = '0;
          end else begin
            addr_nxt = mem_addr + 1'b1;
          end
        end else if (dcnt == DLAST) begin
          drain_nxt = 1'b0;
          addr_nxt  = '0;
          st_nxt    = (st == R0) ? WA : DONE;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they land in flops with it.
  always_comb begin
    ext     = {{DATA_WIDTH{1'b0}}, addr_nxt};
    pat     = ext[DATA_WIDTH-1:0];
    rd_d    = ((st_nxt == R0) || (st_nxt == RA)) && !drain_nxt;
    wr_d    = (st_nxt == W0) || (st_nxt == WA);
    wdata_d = (st_nxt == WA) ? pat : '0;
    exp_d   = (st_nxt == RA) ? pat : '0;
    phase_d = (st_nxt == RA) ? PH_RA : PH_R0;
    busy_d  = wr_d || (st_nxt == R0) || (st_nxt == RA);
    done_d  = (st_nxt == DONE);
  end

  assign pass = done && (err_count == '0);

  mem_bist_cmp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY),
    .ERR_W      (ERR_W)
  ) u_cmp (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .rd         (mem_read),
    .addr       (mem_addr),
    .exp        (exp_q),
    .phase      (phase_q),
    .rdata      (mem_rdata),
    .err_count  (err_count),
    .fail_addr  (fail_addr),
    .fail_data  (fail_data),
    .fail_phase (fail_phase)
  );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl against a behavioural memory with selectable faults.
module tb_mem_bist_ctrl;

  localparam int DEPTH   = 512;
  localparam int EXP_LAT = 4 * DEPTH + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass, fail_phase, mem_read, mem_write;
  logic [15:0] err_count;
  logic [8:0]  fail_addr, mem_addr;
  logic [7:0]  fail_data, mem_wdata, mem_rdata;

  logic        busy2, done2, pass2, fail_phase2, mem_read2, mem_write2;
  logic [3:0]  err_count2;
  logic [8:0]  fail_addr2, mem_addr2;
  logic [7:0]  fail_data2, mem_wdata2;

  int tests = 0;
  int fails = 0;
  int mode  = 0;   // 0 clean, 1 addr5 bit0 stuck-at-1, 2 reads all FF, 3 addr[8] ignored
  int edges, busy_lo, both_hi;
  logic [7:0] wd256, wd511;
  logic [7:0] mem [DEPTH];
  logic [8:0] idx;

  always #5 clk = ~clk;

  mem_bist_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data),
    .fail_phase(fail_phase), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_bist_ctrl #(.ERR_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .fail_addr(fail_addr2), .fail_data(fail_data2),
    .fail_phase(fail_phase2), .mem_read(mem_read2), .mem_write(mem_write2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(8'hFF)
  );

  always_comb idx = (mode == 3) ? {1'b0, mem_addr[7:0]} : mem_addr;

  always @(posedge clk) begin
    if (mem_write) mem[idx] <= mem_wdata;
    if (mem_read) begin
      if (mode == 2)                        mem_rdata <= 8'hFF;
      else if (mode == 1 && mem_addr == 5)  mem_rdata <= mem[idx] | 8'h01;
      else                                  mem_rdata <= mem[idx];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start, then count edges until done; optionally pulse start mid-run.
  task automatic run(input bit pulse_mid);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 0; busy_lo = 0; both_hi = 0;
    while (!done && edges < 3000) begin
      if (!busy) busy_lo++;
      if (mem_read && mem_write) both_hi++;
      if (mem_write && mem_addr == 9'd256) wd256 = mem_wdata;
      if (mem_write && mem_addr == 9'd511) wd511 = mem_wdata;
      start = pulse_mid && (edges == 100 || edges == 1500);
      @(posedge clk);
      #1 edges++;
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fail_addr", fail_addr, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_addr", mem_addr, 0);
    @(negedge clk) rst = 1'b0;

    mode = 0;
    run(1'b0);
    chk("clean_latency", edges, EXP_LAT);
    chk("clean_busy_span", busy_lo, 0);
    chk("clean_strobe_excl", both_hi, 0);
    chk("clean_pass", pass, 1);
    chk("clean_err", err_count, 0);
    chk("wa_pat_256", wd256, 8'h00);
    chk("wa_pat_511", wd511, 8'hFF);
    repeat (5) @(posedge clk);
    #1;
    chk("done_hold", {done, busy, mem_read, mem_write}, 4'b1000);

    mode = 1;
    run(1'b0);
    chk("stuck_latency", edges, EXP_LAT);
    chk("stuck_err", err_count, 1);
    chk("stuck_fail_addr", fail_addr, 5);
    chk("stuck_fail_data", fail_data, 8'h01);
    chk("stuck_fail_phase", fail_phase, 0);
    chk("stuck_pass", pass, 0);

    mode = 2;
    run(1'b0);
    chk("ff_err", err_count, 1022);
    chk("ff_fail_addr", fail_addr, 0);
    chk("ff_fail_data", fail_data, 8'hFF);
    chk("ff_fail_phase", fail_phase, 0);
    chk("ff_pass", pass, 0);
    chk("sat_done", done2, 1);
    chk("sat_err", err_count2, 15);
    chk("sat_pass", pass2, 0);

    // Low-byte pattern writes the same value to both aliases, so this passes.
    mode = 3;
    run(1'b0);
    chk("alias_err", err_count, 0);
    chk("alias_pass", pass, 1);

    mode = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (700) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_strobes", {mem_read, mem_write}, 0);
    chk("abort_flags", {busy, done, pass}, 0);
    chk("abort_err", err_count, 0);
    chk("abort_addr", mem_addr, 0);
    @(negedge clk) rst = 1'b0;

    run(1'b1);
    chk("restart_latency", edges, EXP_LAT);
    chk("restart_busy_span", busy_lo, 0);
    chk("restart_pass", pass, 1);
    chk("restart_err", err_count, 0);
    chk("restart_fail_addr", fail_addr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
